// File: rtl/calc1_core_if.sv
// Request/response bundle for the four independent calc1_core ports.
// Request vectors are MSB-first (index 0 = MSB).
interface calc1_core_if;
    logic [0:3]  req1_cmd_in;
    logic [0:3]  req2_cmd_in;
    logic [0:3]  req3_cmd_in;
    logic [0:3]  req4_cmd_in;
    logic [0:31] req1_data_in;
    logic [0:31] req2_data_in;
    logic [0:31] req3_data_in;
    logic [0:31] req4_data_in;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic [31:0] out_data4;
    logic [1:0]  out_resp1;
    logic [1:0]  out_resp2;
    logic [1:0]  out_resp3;
    logic [1:0]  out_resp4;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_data1, out_data2, out_data3, out_data4,
        input  out_resp1, out_resp2, out_resp3, out_resp4
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_data1, out_data2, out_data3, out_data4,
        output out_resp1, out_resp2, out_resp3, out_resp4
    );
endinterface

// File: rtl/calc1_core.sv
// Four-port unsigned 32-bit calculator: two-cycle request (cmd+op1, op2),
// one-cycle registered response two edges after operand2 is offered.
module calc1_core (
    input  logic        c_clk,
    input  logic [1:7]  reset,
    calc1_core_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    logic [0:3]  w_cmd_in  [4];
    logic [0:31] w_data_in [4];
    logic [31:0] w_out_data[4];
    logic [1:0]  w_out_resp[4];

    // Only reset[1] is functional; the rest of the vector is don't-care.
    logic w_unused_reset;
    assign w_unused_reset = &{1'b0, reset[2:7]};

    assign w_cmd_in[0]  = bus.req1_cmd_in;
    assign w_cmd_in[1]  = bus.req2_cmd_in;
    assign w_cmd_in[2]  = bus.req3_cmd_in;
    assign w_cmd_in[3]  = bus.req4_cmd_in;
    assign w_data_in[0] = bus.req1_data_in;
    assign w_data_in[1] = bus.req2_data_in;
    assign w_data_in[2] = bus.req3_data_in;
    assign w_data_in[3] = bus.req4_data_in;

    assign bus.out_data1 = w_out_data[0];
    assign bus.out_data2 = w_out_data[1];
    assign bus.out_data3 = w_out_data[2];
    assign bus.out_data4 = w_out_data[3];
    assign bus.out_resp1 = w_out_resp[0];
    assign bus.out_resp2 = w_out_resp[1];
    assign bus.out_resp3 = w_out_resp[2];
    assign bus.out_resp4 = w_out_resp[3];

    for (genvar g = 0; g < 4; g++) begin : g_port
        state_t      r_state;
        state_t      w_next;
        logic [3:0]  r_cmd;
        logic [31:0] r_op1;
        logic [31:0] r_op2;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        w_load_op1;
        logic        w_load_op2;
        logic        w_emit;
        logic [32:0] w_sum;
        logic [31:0] w_res_data;
        logic [1:0]  w_res_resp;

        // State register
        always_ff @(posedge c_clk) begin
            if (reset[1]) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        // Next-state logic; EXEC accepts a new request just like IDLE
        always_comb begin
            w_next = r_state;
            case (r_state)
                ST_IDLE, ST_EXEC: w_next = (w_cmd_in[g] != 4'd0) ? ST_OP2 : ST_IDLE;
                ST_OP2:           w_next = ST_EXEC;
                default:          w_next = ST_IDLE;
            endcase
        end

        // State-decoded controls
        always_comb begin
            w_load_op1 = 1'b0;
            w_load_op2 = 1'b0;
            w_emit     = 1'b0;
            case (r_state)
                ST_IDLE: w_load_op1 = (w_cmd_in[g] != 4'd0);
                ST_OP2:  w_load_op2 = 1'b1;
                ST_EXEC: begin
                    w_emit     = 1'b1;
                    w_load_op1 = (w_cmd_in[g] != 4'd0);
                end
                default: w_load_op1 = 1'b0;
            endcase
        end

        // Arithmetic on the captured operands; shift amount is op2's low 5 bits
        always_comb begin
            w_sum      = {1'b0, r_op1} + {1'b0, r_op2};
            w_res_data = 32'd0;
            w_res_resp = 2'd2;
            case (r_cmd)
                4'd1: begin
                    if (w_sum[32]) begin
                        w_res_resp = 2'd2;
                    end else begin
                        w_res_resp = 2'd1;
                        w_res_data = w_sum[31:0];
                    end
                end
                4'd2: begin
                    if (r_op2 > r_op1) begin
                        w_res_resp = 2'd2;
                    end else begin
                        w_res_resp = 2'd1;
                        w_res_data = r_op1 - r_op2;
                    end
                end
                4'd5: begin
                    w_res_resp = 2'd1;
                    w_res_data = r_op1 << r_op2[4:0];
                end
                4'd6: begin
                    w_res_resp = 2'd1;
                    w_res_data = r_op1 >> r_op2[4:0];
                end
                default: begin
                    w_res_resp = 2'd2;
                    w_res_data = 32'd0;
                end
            endcase
        end

        // Operand capture and one-cycle response register
        always_ff @(posedge c_clk) begin
            if (reset[1]) begin
                r_cmd  <= 4'd0;
                r_op1  <= 32'd0;
                r_op2  <= 32'd0;
                r_data <= 32'd0;
                r_resp <= 2'd0;
            end else begin
                if (w_load_op1) begin
                    r_cmd <= w_cmd_in[g];
                    r_op1 <= w_data_in[g];
                end
                if (w_load_op2) begin
                    r_op2 <= w_data_in[g];
                end
                if (w_emit) begin
                    r_data <= w_res_data;
                    r_resp <= w_res_resp;
                end else begin
                    r_data <= 32'd0;
                    r_resp <= 2'd0;
                end
            end
        end

        assign w_out_data[g] = r_data;
        assign w_out_resp[g] = r_resp;
    end

endmodule

// File: tb/tb_calc1_core.sv
// Self-checking bench for calc1_core: directed vectors with literal expectations
// plus randomized traffic on all four ports against a behavioural model.
module tb_calc1_core;

    localparam int MAXC = 4096;

    logic       clk;
    logic [1:7] reset;
    calc1_core_if bus();

    calc1_core u_dut (
        .c_clk (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Expected response per port per rising-edge index (0 = no response)
    bit [1:0]  exp_resp [4][MAXC];
    bit [31:0] exp_data [4][MAXC];

    logic [3:0]  drv_cmd [4];
    logic [31:0] drv_data[4];
    bit          phase   [4];
    bit [3:0]    pcmd    [4];
    bit [31:0]   pop1    [4];

    logic [31:0] mon_data[4];
    logic [1:0]  mon_resp[4];
    assign mon_data[0] = bus.out_data1;
    assign mon_data[1] = bus.out_data2;
    assign mon_data[2] = bus.out_data3;
    assign mon_data[3] = bus.out_data4;
    assign mon_resp[0] = bus.out_resp1;
    assign mon_resp[1] = bus.out_resp2;
    assign mon_resp[2] = bus.out_resp3;
    assign mon_resp[3] = bus.out_resp4;

    function automatic bit [33:0] calc(input bit [3:0] cmd, input bit [31:0] a, input bit [31:0] b);
        longint unsigned s;
        calc = {2'd2, 32'd0};
        case (cmd)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s <= 64'hFFFF_FFFF) calc = {2'd1, s[31:0]};
            end
            4'd2: if (a >= b) calc = {2'd1, a - b};
            4'd5: calc = {2'd1, a << (b % 32)};
            4'd6: calc = {2'd1, a >> (b % 32)};
            default: calc = {2'd2, 32'd0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got resp=%0d data=%h, expected resp=%0d data=%h",
                     name, act[33:32], act[31:0], exp[33:32], exp[31:0]);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model
    task automatic tick(input bit rst);
        int e;
        bit [33:0] r;
        @(negedge clk);
        e = cyc + 1;
        reset = {rst, 6'bxxxxxx};
        bus.req1_cmd_in  = drv_cmd[0];
        bus.req2_cmd_in  = drv_cmd[1];
        bus.req3_cmd_in  = drv_cmd[2];
        bus.req4_cmd_in  = drv_cmd[3];
        bus.req1_data_in = drv_data[0];
        bus.req2_data_in = drv_data[1];
        bus.req3_data_in = drv_data[2];
        bus.req4_data_in = drv_data[3];
        for (int p = 0; p < 4; p++) begin
            if (rst) begin
                phase[p] = 1'b0;
                exp_resp[p][e] = 2'd0;  exp_data[p][e] = 32'd0;
                exp_resp[p][e+1] = 2'd0; exp_data[p][e+1] = 32'd0;
            end else if (phase[p]) begin
                r = calc(pcmd[p], pop1[p], drv_data[p]);
                exp_resp[p][e+1] = r[33:32];
                exp_data[p][e+1] = r[31:0];
                phase[p] = 1'b0;
            end else if (drv_cmd[p] != 4'd0) begin
                pcmd[p]  = drv_cmd[p];
                pop1[p]  = drv_data[p];
                phase[p] = 1'b1;
            end
        end
    endtask

    task automatic idle_all();
        for (int p = 0; p < 4; p++) begin
            drv_cmd[p]  = 4'd0;
            drv_data[p] = $urandom;
        end
    endtask

    // One request on port p, then a literal check of the response cycle
    task automatic do_req(input string name, input int p, input bit [3:0] cmd,
                          input bit [31:0] a, input bit [31:0] b,
                          input bit [1:0] er, input bit [31:0] ed);
        idle_all();
        drv_cmd[p] = cmd; drv_data[p] = a;
        tick(1'b0);
        drv_cmd[p] = 4'hF; drv_data[p] = b;
        tick(1'b0);
        idle_all();
        tick(1'b0);
        @(posedge clk); #2;
        chk(name, {mon_resp[p], mon_data[p]}, {er, ed});
    endtask

    function automatic bit [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       rnd_data = $urandom_range(0, 63);
            1:       rnd_data = 32'hFFFF_FFFF - $urandom_range(0, 63);
            default: rnd_data = $urandom;
        endcase
    endfunction

    function automatic bit [3:0] rnd_cmd();
        case ($urandom_range(0, 9))
            0, 1, 2: rnd_cmd = 4'd0;
            3, 8:    rnd_cmd = 4'd1;
            4, 9:    rnd_cmd = 4'd2;
            5:       rnd_cmd = 4'd5;
            6:       rnd_cmd = 4'd6;
            default: rnd_cmd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(3, 4))
                                                           : 4'($urandom_range(7, 15));
        endcase
    endfunction

    // Every-cycle comparison of all four ports against the model
    always @(posedge clk) begin
        int c;
        cyc = cyc + 1;
        c = cyc;
        #1;
        if (chk_en) begin
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("model p%0d edge%0d", p + 1, c),
                    {mon_resp[p], mon_data[p]}, {exp_resp[p][c], exp_data[p][c]});
            end
        end
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            phase[p] = 1'b0; pcmd[p] = 4'd0; pop1[p] = 32'd0;
        end
        idle_all();

        // Pin the model itself
        chk("model add", calc(4'd1, 32'h0000_0001, 32'h01FF_FFFF), {2'd1, 32'h0200_0000});
        chk("model ovf", calc(4'd1, 32'hFFFF_FFFF, 32'h0000_0001), {2'd2, 32'd0});
        chk("model sub", calc(4'd2, 32'h0000_0001, 32'h0000_000F), {2'd2, 32'd0});
        chk("model shr", calc(4'd6, 32'h8000_0000, 32'd31), {2'd1, 32'h0000_0001});

        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            if (i == 1) chk_en = 1'b1;
        end
        idle_all();
        for (int i = 0; i < 3; i++) tick(1'b0);
        @(posedge clk); #2;
        for (int p = 0; p < 4; p++)
            chk($sformatf("reset idle p%0d", p + 1), {mon_resp[p], mon_data[p]}, {2'd0, 32'd0});

        do_req("add small",   0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
        do_req("add mid",     0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
        do_req("add zero",    0, 4'd1, 32'd0, 32'd0, 2'd1, 32'd0);
        do_req("add ovf",     0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0);
        do_req("sub under",   0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0);
        do_req("sub equal",   0, 4'd2, 32'h0000_000F, 32'h0000_000F, 2'd1, 32'd0);
        do_req("cmd3",        0, 4'd3, 32'd1, 32'd1, 2'd2, 32'd0);
        do_req("cmd4",        0, 4'd4, 32'd1, 32'd1, 2'd2, 32'd0);
        tick(1'b0);
        @(posedge clk); #2;
        chk("resp one cycle", {mon_resp[0], mon_data[0]}, {2'd0, 32'd0});

        for (int k = 0; k < 31; k++)
            do_req($sformatf("walk1 k%0d", k), 0, 4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k);
        do_req("shl 31",  0, 4'd5, 32'h0000_0001, 32'd31, 2'd1, 32'h8000_0000);
        do_req("shr 31",  0, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001);
        do_req("shl 32",  1, 4'd5, 32'h1234_5678, 32'd32, 2'd1, 32'h1234_5678);
        do_req("shr 32",  2, 4'd6, 32'h1234_5678, 32'd32, 2'd1, 32'h1234_5678);

        // All four ports on the same edge
        drv_cmd[0] = 4'd1; drv_data[0] = 32'h10;
        drv_cmd[1] = 4'd2; drv_data[1] = 32'h30;
        drv_cmd[2] = 4'd5; drv_data[2] = 32'h3;
        drv_cmd[3] = 4'd3; drv_data[3] = 32'h1;
        tick(1'b0);
        drv_data[0] = 32'h20; drv_data[1] = 32'h10; drv_data[2] = 32'd4; drv_data[3] = 32'd9;
        tick(1'b0);
        idle_all();
        tick(1'b0);
        @(posedge clk); #2;
        chk("quad p1 add", {mon_resp[0], mon_data[0]}, {2'd1, 32'h30});
        chk("quad p2 sub", {mon_resp[1], mon_data[1]}, {2'd1, 32'h20});
        chk("quad p3 shl", {mon_resp[2], mon_data[2]}, {2'd1, 32'h30});
        chk("quad p4 inv", {mon_resp[3], mon_data[3]}, {2'd2, 32'd0});

        // Reset during the operand2 cycle drops the request
        idle_all();
        drv_cmd[0] = 4'd1; drv_data[0] = 32'd5;
        tick(1'b0);
        drv_data[0] = 32'd6;
        tick(1'b1);
        idle_all();
        tick(1'b0);
        @(posedge clk); #2;
        chk("reset in op2 T+2", {mon_resp[0], mon_data[0]}, {2'd0, 32'd0});
        tick(1'b0);
        @(posedge clk); #2;
        chk("reset in op2 T+3", {mon_resp[0], mon_data[0]}, {2'd0, 32'd0});

        // Randomized traffic on all ports with occasional reset
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 4; p++) begin
                drv_cmd[p]  = rnd_cmd();
                drv_data[p] = rnd_data();
            end
            tick($urandom_range(0, 299) == 0);
        end
        idle_all();
        for (int i = 0; i < 4; i++) tick(1'b0);
        @(posedge clk); #2;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
